// File: rtl/freq_track_ctrl.sv
// -----------------------------------------------------------------------------
// freq_track_ctrl
//
// Purpose: phase-tracking controller for a resonant drive. Requests a
// voltage/current edge-time measurement, computes phase = i_edge - v_edge, and
// nudges the 16-bit drive frequency word by STEP toward zero phase, clamped to
// [F_MIN, F_MAX]. A measurement that never completes within TIMEOUT cycles,
// or reports a zero voltage period, parks the controller in FAULT until
// enable is dropped.
//
// Optional feature: define FT_LOCK_DET_EN to build the lock detector
// (locked=1 after LOCK_CNT consecutive in-band adjusts). Without it, locked=0.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   enable       tracking enable; low forces IDLE next cycle
//   meas_done    single-cycle measurement-complete pulse
//   v_edge_time  voltage edge timestamp (clk counts), valid with meas_done
//   i_edge_time  current edge timestamp (clk counts), valid with meas_done
//   v_period     voltage period (clk counts), valid with meas_done
//   meas_start   one-cycle pulse on the first cycle of every MEASURE visit
//   freq_word    drive frequency word; shows the new value in its load cycle
//   freq_load    one-cycle pulse whenever freq_word takes a new value
//   state        FSM state: 0 IDLE, 1 MEASURE, 2 ADJUST, 3 FAULT
//   locked       lock indication (FT_LOCK_DET_EN builds only)
//   fault        high while in FAULT
// -----------------------------------------------------------------------------
module freq_track_ctrl #(
    parameter int unsigned F_INIT    = 40000,
    parameter int unsigned F_MIN     = 20000,
    parameter int unsigned F_MAX     = 60000,
    parameter int unsigned STEP      = 16,
    parameter int unsigned PHASE_TOL = 8,
    parameter int unsigned TIMEOUT   = 1_000_000,
    parameter int unsigned LOCK_CNT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        meas_done,
    input  logic [31:0] v_edge_time,
    input  logic [31:0] i_edge_time,
    input  logic [31:0] v_period,
    output logic        meas_start,
    output logic [15:0] freq_word,
    output logic        freq_load,
    output logic [1:0]  state,
    output logic        locked,
    output logic        fault
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_ADJUST  = 2'd2,
        S_FAULT   = 2'd3
    } state_t;

    localparam logic signed [32:0] TOL_P = 33'(PHASE_TOL);
    localparam logic signed [32:0] TOL_N = -TOL_P;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_tmo_cnt;
    logic               r_first;
    logic signed [32:0] r_phase;
    logic [15:0]        r_freq_word;
    logic [15:0]        w_word_nxt;
    logic [15:0]        w_adj_word;
    logic [16:0]        w_inc;
    logic [16:0]        w_dec;
    logic               w_timeout;
    logic               w_phase_hi;
    logic               w_phase_lo;
    logic signed [32:0] w_phase;

    // Zero-extend both timestamps so the 33-bit difference never wraps.
    assign w_phase    = $signed({1'b0, i_edge_time}) - $signed({1'b0, v_edge_time});
    assign w_phase_hi = (r_phase > TOL_P);
    assign w_phase_lo = (r_phase < TOL_N);
    assign w_timeout  = (r_tmo_cnt >= 32'(TIMEOUT - 1));

    // 17-bit intermediates: bit 16 catches borrow/carry before clamping.
    assign w_inc = {1'b0, r_freq_word} + 17'(STEP);
    assign w_dec = {1'b0, r_freq_word} - 17'(STEP);

    always_comb begin
        w_adj_word = r_freq_word;
        if (w_phase_hi)
            w_adj_word = (w_dec[16] || (w_dec < 17'(F_MIN))) ? 16'(F_MIN) : w_dec[15:0];
        else if (w_phase_lo)
            w_adj_word = (w_inc > 17'(F_MAX)) ? 16'(F_MAX) : w_inc[15:0];
    end

    always_comb begin
        w_word_nxt = r_freq_word;
        if (enable) begin
            if (r_state == S_IDLE)
                w_word_nxt = 16'(F_INIT);
            else if (r_state == S_ADJUST)
                w_word_nxt = w_adj_word;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples the pre-edge values regardless of block order.
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_state_nxt
        // unassigned, which would infer a latch.
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    w_state_nxt = S_MEASURE;
                S_MEASURE: begin
                    // meas_done takes priority over a coincident timeout.
                    if (meas_done)
                        w_state_nxt = (v_period == 32'd0) ? S_FAULT : S_ADJUST;
                    else if (w_timeout)
                        w_state_nxt = S_FAULT;
                end
                S_ADJUST:  w_state_nxt = S_MEASURE;
                S_FAULT:   w_state_nxt = S_FAULT;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output logic.
    always_comb begin
        meas_start = enable && (r_state == S_MEASURE) && r_first;
        freq_load  = enable && ((r_state == S_IDLE) ||
                                ((r_state == S_ADJUST) && (w_adj_word != r_freq_word)));
        fault      = (r_state == S_FAULT);
        freq_word  = w_word_nxt;
        state      = r_state;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_freq_word <= 16'(F_INIT);
            r_tmo_cnt   <= '0;
            r_first     <= 1'b0;
            r_phase     <= '0;
        end else begin
            r_freq_word <= w_word_nxt;
            r_first     <= (w_state_nxt == S_MEASURE) && (r_state != S_MEASURE);
            // Counter runs only while staying in MEASURE, so every entry starts at 0.
            if ((r_state == S_MEASURE) && (w_state_nxt == S_MEASURE))
                r_tmo_cnt <= r_tmo_cnt + 32'd1;
            else
                r_tmo_cnt <= '0;
            if (enable && (r_state == S_MEASURE) && meas_done)
                r_phase <= w_phase;
        end
    end

`ifdef FT_LOCK_DET_EN
    localparam int unsigned LW = $clog2(LOCK_CNT + 1) + 1;

    logic [LW-1:0] r_lock_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lock_cnt <= '0;
        end else if ((w_state_nxt == S_IDLE) || (w_state_nxt == S_FAULT)) begin
            r_lock_cnt <= '0;
        end else if (r_state == S_ADJUST) begin
            if (w_phase_hi || w_phase_lo)
                r_lock_cnt <= '0;
            else if (r_lock_cnt < LW'(LOCK_CNT))
                r_lock_cnt <= r_lock_cnt + 1'b1;
        end
    end

    assign locked = (r_lock_cnt >= LW'(LOCK_CNT));
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_freq_track_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freq_track_ctrl
//
// Self-checking bench for freq_track_ctrl. A narrow clamp window
// (F_MIN=39980, F_MAX=40030) lets both clamps be reached in a few adjusts,
// and a short TIMEOUT keeps the timeout cases brief. Inputs are driven 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_freq_track_ctrl;

    localparam int TMO = 64;

`ifdef FT_LOCK_DET_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        meas_done = 1'b0;
    logic [31:0] v_edge_time = '0;
    logic [31:0] i_edge_time = '0;
    logic [31:0] v_period = 32'd2500;
    logic        meas_start;
    logic [15:0] freq_word;
    logic        freq_load;
    logic [1:0]  state;
    logic        locked;
    logic        fault;

    always #5 clk = ~clk;

    freq_track_ctrl #(
        .F_INIT(40000), .F_MIN(39980), .F_MAX(40030), .STEP(16),
        .PHASE_TOL(8), .TIMEOUT(TMO), .LOCK_CNT(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .meas_done(meas_done),
        .v_edge_time(v_edge_time), .i_edge_time(i_edge_time), .v_period(v_period),
        .meas_start(meas_start), .freq_word(freq_word), .freq_load(freq_load),
        .state(state), .locked(locked), .fault(fault)
    );

    typedef struct {
        logic [31:0] v;
        logic [31:0] i;
        logic [15:0] exp_word;
        logic        exp_load;
        logic        exp_lock;
    } vec_t;

    typedef struct {
        logic [15:0] word;
        logic        load;
        logic        lock;
    } exp_t;

    vec_t vecs[20];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic setvec(input int idx, input logic [31:0] v, input logic [31:0] i,
                          input logic [15:0] w, input logic ld, input logic lk);
        vecs[idx] = '{v, i, w, ld, lk};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   n;

        // Applied in order from freq_word=40000; window [39980, 40030], STEP 16.
        setvec( 0, 32'd100,        32'd150,        16'd39984, 1'b1, 1'b0);
        setvec( 1, 32'd0,          32'd50,         16'd39980, 1'b1, 1'b0);
        setvec( 2, 32'd0,          32'd50,         16'd39980, 1'b0, 1'b0);
        setvec( 3, 32'd50,         32'd0,          16'd39996, 1'b1, 1'b0);
        setvec( 4, 32'd10,         32'd18,         16'd39996, 1'b0, 1'b0);
        setvec( 5, 32'd18,         32'd10,         16'd39996, 1'b0, 1'b0);
        setvec( 6, 32'd500,        32'd500,        16'd39996, 1'b0, 1'b0);
        setvec( 7, 32'd0,          32'd9,          16'd39980, 1'b1, 1'b0);
        setvec( 8, 32'd9,          32'd0,          16'd39996, 1'b1, 1'b0);
        setvec( 9, 32'hFFFF_FFFF,  32'd0,          16'd40012, 1'b1, 1'b0);
        setvec(10, 32'd0,          32'hFFFF_FFFF,  16'd39996, 1'b1, 1'b0);
        setvec(11, 32'd50,         32'd0,          16'd40012, 1'b1, 1'b0);
        setvec(12, 32'd50,         32'd0,          16'd40028, 1'b1, 1'b0);
        setvec(13, 32'd50,         32'd0,          16'd40030, 1'b1, 1'b0);
        setvec(14, 32'd50,         32'd0,          16'd40030, 1'b0, 1'b0);
        setvec(15, 32'd0,          32'd3,          16'd40030, 1'b0, 1'b0);
        setvec(16, 32'd0,          32'd3,          16'd40030, 1'b0, 1'b0);
        setvec(17, 32'd0,          32'd3,          16'd40030, 1'b0, 1'b0);
        setvec(18, 32'd0,          32'd3,          16'd40030, 1'b0, 1'b1);
        setvec(19, 32'd0,          32'd20,         16'd40014, 1'b1, 1'b0);

        // Reset state.
        repeat (2) cyc();
        mid();
        check("rst state",      state,      0);
        check("rst freq_word",  freq_word,  40000);
        check("rst freq_load",  freq_load,  0);
        check("rst meas_start", meas_start, 0);
        check("rst locked",     locked,     0);
        check("rst fault",      fault,      0);
        cyc(); rst = 1'b1; mid();
        check("idle state", state, 0);

        // Enable: load pulse in IDLE, meas_start one cycle later.
        cyc(); enable = 1'b1; mid();
        check("en state",      state,      0);
        check("en freq_load",  freq_load,  1);
        check("en freq_word",  freq_word,  40000);
        check("en meas_start", meas_start, 0);
        cyc(); mid();
        check("meas1 state",      state,      1);
        check("meas1 meas_start", meas_start, 1);
        check("meas1 freq_load",  freq_load,  0);

        // Table-driven adjust sequence.
        for (int k = 0; k < 20; k++) begin
            for (int d = 0; d < k % 3; d++) begin
                cyc(); mid();
                check($sformatf("vec%0d wait meas_start", k), meas_start, 0);
            end
            cyc();
            meas_done = 1'b1; v_edge_time = vecs[k].v; i_edge_time = vecs[k].i;
            sb.push_back('{vecs[k].exp_word, vecs[k].exp_load, vecs[k].exp_lock});
            mid();
            check($sformatf("vec%0d done state", k), state, 1);
            cyc(); meas_done = 1'b0; mid();
            check($sformatf("vec%0d adj state", k), state, 2);
            if (state == 2'd2 && sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("vec%0d freq_word", k), freq_word, e.word);
                check($sformatf("vec%0d freq_load", k), freq_load, e.load);
                cyc(); mid();
                check($sformatf("vec%0d restart", k), meas_start, 1);
                check($sformatf("vec%0d locked", k), locked, LOCK_EN ? e.lock : 1'b0);
            end else begin
                check($sformatf("vec%0d adjust reached", k), 0, 1);
                sb.delete();
                cyc(); mid();
            end
        end

        // Timeout into FAULT after exactly TMO MEASURE cycles.
        n = 0;
        do begin
            cyc(); mid(); n++;
        end while (state != 2'd3 && n < TMO + 10);
        check("timeout cycles",     n,          TMO);
        check("timeout fault",      fault,      1);
        check("timeout freq_word",  freq_word,  40014);
        check("timeout meas_start", meas_start, 0);

        // meas_done ignored in FAULT.
        cyc(); meas_done = 1'b1; v_edge_time = 32'd0; i_edge_time = 32'd50; mid();
        cyc(); meas_done = 1'b0; mid();
        check("fault ignores done", state,      3);
        check("fault meas_start",   meas_start, 0);
        check("fault held",         fault,      1);

        // Disable clears fault and holds freq_word.
        cyc(); enable = 1'b0; mid();
        cyc(); mid();
        check("dis state",     state,     0);
        check("dis fault",     fault,     0);
        check("dis freq_word", freq_word, 40014);
        check("dis freq_load", freq_load, 0);

        // Re-enable reloads F_INIT.
        cyc(); enable = 1'b1; mid();
        check("reen freq_load", freq_load, 1);
        check("reen freq_word", freq_word, 40000);
        cyc(); mid();
        check("reen meas_start", meas_start, 1);

        // meas_done coincident with timeout expiry wins.
        repeat (TMO - 2) begin cyc(); mid(); end
        cyc(); meas_done = 1'b1; v_edge_time = 32'd100; i_edge_time = 32'd150; mid();
        check("coinc measure", state, 1);
        cyc(); meas_done = 1'b0; mid();
        check("coinc adjust",    state,     2);
        check("coinc freq_word", freq_word, 39984);
        check("coinc freq_load", freq_load, 1);

        // Zero voltage period faults.
        cyc(); mid();
        check("zp meas_start", meas_start, 1);
        cyc(); meas_done = 1'b1; v_period = 32'd0; mid();
        cyc(); meas_done = 1'b0; v_period = 32'd2500; mid();
        check("zp state",     state,     3);
        check("zp fault",     fault,     1);
        check("zp freq_word", freq_word, 39984);

        // Disable during ADJUST holds the word and suppresses the load.
        cyc(); enable = 1'b0; mid();
        cyc(); enable = 1'b1; mid();
        check("reen2 freq_word", freq_word, 40000);
        cyc(); mid();
        cyc(); meas_done = 1'b1; v_edge_time = 32'd0; i_edge_time = 32'd50; mid();
        cyc(); meas_done = 1'b0; enable = 1'b0; mid();
        check("adjdis state",     state,     2);
        check("adjdis freq_load", freq_load, 0);
        check("adjdis freq_word", freq_word, 40000);
        cyc(); mid();
        check("adjdis idle", state, 0);

        // Reset mid-measurement, then a late meas_done is ignored.
        cyc(); enable = 1'b1; mid();
        cyc(); mid();
        cyc(); mid();
        check("pre-rst state", state, 1);
        cyc(); rst = 1'b0; enable = 1'b0; mid();
        check("async rst state",      state,      0);
        check("async rst meas_start", meas_start, 0);
        cyc(); rst = 1'b1; mid();
        cyc(); meas_done = 1'b1; v_edge_time = 32'd0; i_edge_time = 32'd50; mid();
        cyc(); meas_done = 1'b0; mid();
        check("late done state",      state,      0);
        check("late done freq_load",  freq_load,  0);
        check("late done meas_start", meas_start, 0);
        check("late done freq_word",  freq_word,  40000);
        check("late done locked",     locked,     0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
